// File: rtl/core_clk_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | clk_ctrl_pkg : shared run-state encoding and tick counter width       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package clk_ctrl_pkg;

  typedef enum logic [1:0] {
    HALT = 2'b00,
    RUN  = 2'b01,
    STEP = 2'b10
  } run_state_e;

  localparam int TICK_CNT_W = 32;

endpackage
`default_nettype wire

// File: rtl/core_clk_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | core_clk_ctrl_if : run-control requests, divisor config and tick bus  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface core_clk_ctrl_if
  import clk_ctrl_pkg::*;
#(
  parameter int CNT_W = 25
);

  logic                  run_req;
  logic                  halt_req;
  logic                  step_req;
  logic                  cfg_valid;
  logic [CNT_W-1:0]      cfg_div;
  logic                  cfg_ready;
  logic                  tick;
  run_state_e            state_o;
  logic                  step_done;
  logic [TICK_CNT_W-1:0] tick_count;

  modport master (
    output run_req, halt_req, step_req, cfg_valid, cfg_div,
    input  cfg_ready, tick, state_o, step_done, tick_count
  );

  modport slave (
    input  run_req, halt_req, step_req, cfg_valid, cfg_div,
    output cfg_ready, tick, state_o, step_done, tick_count
  );

endinterface
`default_nettype wire

// File: rtl/core_clk_ctrl_period_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | period_counter : divisor counter, wraps at div_i-1                    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module period_counter #(
  parameter int CNT_W = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic [CNT_W-1:0] div_i,
  output logic             wrap_o
);

  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign wrap_o = (cnt_q == (div_i - C_ONE));

  // clear has priority so a halt in the wrap cycle still lands on zero
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = wrap_o ? '0 : (cnt_q + C_ONE);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/core_clk_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | core_clk_ctrl : run/halt/step scheduler issuing core tick enables     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module core_clk_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int CNT_W       = 25,
  parameter int DEFAULT_DIV = 25000000
) (
  input  logic           clk,
  input  logic           rst,
  core_clk_ctrl_if.slave ctrl
);

  localparam logic [CNT_W-1:0]      C_DIV_RST = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0]      C_ONE     = CNT_W'(1);
  localparam logic [TICK_CNT_W-1:0] C_TC_ONE  = TICK_CNT_W'(1);

  run_state_e            state_q;
  logic [CNT_W-1:0]      active_div_q;
  logic [CNT_W-1:0]      pend_div_q;
  logic                  pend_valid_q;
  logic [TICK_CNT_W-1:0] tick_count_q;

  logic w_active;
  logic w_wrap;
  logic w_tick;
  logic w_accept;
  logic w_apply;

  assign w_active = (state_q != HALT);
  // tick is gated by halt_req in the same cycle, so it cannot be registered
  assign w_tick   = w_active && w_wrap && !ctrl.halt_req;
  assign w_accept = ctrl.cfg_valid && !pend_valid_q;
  assign w_apply  = pend_valid_q && ((state_q == HALT) || w_tick);

  period_counter #(
    .CNT_W (CNT_W)
  ) u_period (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (!w_active || ctrl.halt_req),
    .enable_i (w_active),
    .div_i    (active_div_q),
    .wrap_o   (w_wrap)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= HALT;
      tick_count_q <= '0;
    end else begin
      if (w_tick) begin
        tick_count_q <= tick_count_q + C_TC_ONE;
      end
      case (state_q)
        HALT: begin
          if (!ctrl.halt_req) begin
            if (ctrl.step_req) begin
              state_q <= STEP;
            end else if (ctrl.run_req) begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          if (ctrl.halt_req) begin
            state_q <= HALT;
          end
        end
        STEP: begin
          if (ctrl.halt_req || w_tick) begin
            state_q <= HALT;
          end
        end
        default: state_q <= HALT;
      endcase
    end
  end

  // a new divisor only lands in HALT or at a wrap, never mid-period
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_div_q <= C_DIV_RST;
      pend_div_q   <= C_DIV_RST;
      pend_valid_q <= 1'b0;
    end else begin
      if (w_accept) begin
        pend_div_q   <= (ctrl.cfg_div == '0) ? C_ONE : ctrl.cfg_div;
        pend_valid_q <= 1'b1;
      end else if (w_apply) begin
        active_div_q <= pend_div_q;
        pend_valid_q <= 1'b0;
      end
    end
  end

  assign ctrl.cfg_ready  = !pend_valid_q;
  assign ctrl.tick       = w_tick;
  assign ctrl.step_done  = w_tick && (state_q == STEP);
  assign ctrl.state_o    = state_q;
  assign ctrl.tick_count = tick_count_q;

endmodule
`default_nettype wire

// File: tb/tb_core_clk_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_core_clk_ctrl : scoreboard bench for the run/step tick scheduler   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_core_clk_ctrl;
  import clk_ctrl_pkg::*;

  localparam int CNT_W       = 25;
  localparam int DEFAULT_DIV = 4;

  typedef struct {
    int          cyc;
    logic        sd;
    logic [31:0] tc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  logic [31:0] exp_tc = 0;
  exp_t q[$];
  exp_t m_e;

  core_clk_ctrl_if #(.CNT_W(CNT_W)) bus ();

  core_clk_ctrl #(
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .ctrl (bus)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor: every tick must match the next expected entry
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (bus.tick === 1'b1) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_tick: tick at cyc %0d, expected no tick", cyc);
        end else begin
          m_e = q.pop_front();
          if (m_e.cyc != cyc || bus.step_done !== m_e.sd || bus.tick_count !== m_e.tc) begin
            n_fail++;
            $display("FAIL tick: got cyc=%0d step_done=%b count=%0d, expected cyc=%0d step_done=%b count=%0d",
                     cyc, bus.step_done, bus.tick_count, m_e.cyc, m_e.sd, m_e.tc);
          end
        end
      end else if (bus.step_done !== 1'b0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL stray_step_done: got %b at cyc %0d, expected 0", bus.step_done, cyc);
      end
    end
  end

  task automatic cyc_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) cyc_wait(1);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_tick(input int c, input logic sd);
    exp_t e;
    e.cyc = c;
    e.sd  = sd;
    e.tc  = exp_tc;
    q.push_back(e);
    exp_tc = exp_tc + 1;
  endtask

  // 0 = run, 1 = step, 2 = halt; s is the edge count at which it was sampled
  task automatic pulse(input int which, output int s);
    s = cyc + 1;
    case (which)
      0:       bus.run_req  = 1'b1;
      1:       bus.step_req = 1'b1;
      default: bus.halt_req = 1'b1;
    endcase
    cyc_wait(1);
    bus.run_req  = 1'b0;
    bus.step_req = 1'b0;
    bus.halt_req = 1'b0;
  endtask

  task automatic set_div(input int d);
    bus.cfg_valid = 1'b1;
    bus.cfg_div   = CNT_W'(d);
    cyc_wait(1);
    bus.cfg_valid = 1'b0;
    chk("cfg_ready_pending", 32'(bus.cfg_ready), 32'd0);
    cyc_wait(2);
    chk("cfg_ready_applied", 32'(bus.cfg_ready), 32'd1);
  endtask

  initial begin
    int s;
    int s2;
    logic [31:0] base;
    bus.run_req   = 1'b0;
    bus.halt_req  = 1'b0;
    bus.step_req  = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_div   = '0;
    cyc_wait(3);
    chk("rst_state", 32'(bus.state_o), 32'(HALT));
    chk("rst_cfg_ready", 32'(bus.cfg_ready), 32'd1);
    chk("rst_tick", 32'(bus.tick), 32'd0);
    chk("rst_step_done", 32'(bus.step_done), 32'd0);
    chk("rst_tick_count", bus.tick_count, 32'd0);
    rst = 1'b1;
    cyc_wait(2);

    // free run at the default divisor of 4
    pulse(0, s);
    push_tick(s + 3, 1'b0);
    push_tick(s + 7, 1'b0);
    push_tick(s + 11, 1'b0);
    wait_cyc(s + 12);
    chk("run_tick_count", bus.tick_count, 32'd3);
    pulse(2, s);
    chk("run_halted", 32'(bus.state_o), 32'(HALT));

    // single step at divisor 3
    set_div(3);
    pulse(1, s);
    push_tick(s + 2, 1'b1);
    wait_cyc(s + 3);
    chk("step_back_to_halt", 32'(bus.state_o), 32'(HALT));
    cyc_wait(20);
    chk("step_tick_count", bus.tick_count, exp_tc);

    // divisor change mid-period: old period completes first
    set_div(5);
    pulse(0, s);
    push_tick(s + 4, 1'b0);
    push_tick(s + 9, 1'b0);
    wait_cyc(s + 5);
    bus.cfg_valid = 1'b1;
    bus.cfg_div   = CNT_W'(2);
    cyc_wait(1);
    bus.cfg_valid = 1'b0;
    chk("midrun_cfg_ready_busy", 32'(bus.cfg_ready), 32'd0);
    push_tick(s + 11, 1'b0);
    push_tick(s + 13, 1'b0);
    push_tick(s + 15, 1'b0);
    wait_cyc(s + 9);
    chk("midrun_cfg_ready_at_wrap", 32'(bus.cfg_ready), 32'd0);
    wait_cyc(s + 10);
    chk("midrun_cfg_ready_after_wrap", 32'(bus.cfg_ready), 32'd1);
    wait_cyc(s + 16);
    pulse(2, s2);
    chk("midrun_halted", 32'(bus.state_o), 32'(HALT));

    // divisor 0 clamps to 1: tick every cycle, halt suppresses its cycle
    set_div(0);
    base = exp_tc;
    pulse(0, s);
    for (int i = 0; i < 7; i++) push_tick(s + i, 1'b0);
    wait_cyc(s + 3);
    chk("div1_count_a", bus.tick_count, base + 32'd3);
    cyc_wait(1);
    chk("div1_count_b", bus.tick_count, base + 32'd4);
    wait_cyc(s + 7);
    pulse(2, s2);
    chk("div1_halted", 32'(bus.state_o), 32'(HALT));
    chk("div1_count_final", bus.tick_count, base + 32'd7);

    // halt and run together on the wrap cycle: no tick, halt wins
    set_div(4);
    pulse(0, s);
    push_tick(s + 3, 1'b0);
    wait_cyc(s + 7);
    bus.run_req  = 1'b1;
    bus.halt_req = 1'b1;
    cyc_wait(1);
    bus.run_req  = 1'b0;
    bus.halt_req = 1'b0;
    chk("halt_prio_state", 32'(bus.state_o), 32'(HALT));
    chk("halt_prio_count", bus.tick_count, exp_tc);
    pulse(1, s2);
    push_tick(s2 + 3, 1'b1);
    wait_cyc(s2 + 5);
    chk("restep_halt", 32'(bus.state_o), 32'(HALT));

    // async reset mid-step with a pending divisor
    pulse(1, s);
    bus.cfg_valid = 1'b1;
    bus.cfg_div   = CNT_W'(7);
    cyc_wait(1);
    bus.cfg_valid = 1'b0;
    chk("prerst_cfg_ready", 32'(bus.cfg_ready), 32'd0);
    chk("prerst_state", 32'(bus.state_o), 32'(STEP));
    rst = 1'b0;
    #1;
    chk("arst_tick", 32'(bus.tick), 32'd0);
    chk("arst_state", 32'(bus.state_o), 32'(HALT));
    chk("arst_cfg_ready", 32'(bus.cfg_ready), 32'd1);
    chk("arst_tick_count", bus.tick_count, 32'd0);
    exp_tc = 0;
    cyc_wait(2);
    rst = 1'b1;
    cyc_wait(1);
    pulse(0, s);
    push_tick(s + 3, 1'b0);
    push_tick(s + 7, 1'b0);
    wait_cyc(s + 8);
    pulse(2, s2);
    cyc_wait(10);
    chk("postrst_tick_count", bus.tick_count, 32'd2);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
